// File: rtl/tl_ul_pkg.sv
// tl_ul_pkg: TL-UL A/D beat payload types and opcode constants shared by the buffer.
package tl_ul_pkg;
  localparam logic [2:0] TL_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] TL_GET             = 3'd4;
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;
  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [3:0]  size;
    logic [3:0]  source;
    logic [31:0] address;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corrupt;
  } tl_a_beat_t;
  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [3:0]  size;
    logic [3:0]  source;
    logic        sink;
    logic        denied;
    logic [31:0] data;
    logic        corrupt;
  } tl_d_beat_t;
endpackage

// File: rtl/tl_ul_fifo.sv
// tl_ul_fifo: count-tracked circular FIFO; FLOW=1 bypasses input to output while empty.
module tl_ul_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter bit FLOW  = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic empty, bypass, push, pop;
  always_comb begin
    empty       = cnt_q == '0;
    in_ready_o  = cnt_q != FULL;
    bypass      = FLOW && empty;
    out_valid_o = !empty || (bypass && in_valid_i);
    out_data_o  = bypass ? in_data_i : mem_q[rd_q];
    // a bypassed beat consumed downstream this cycle never touches storage
    push        = in_valid_i && in_ready_o && !(bypass && out_ready_i);
    pop         = out_ready_i && !empty;
    wr_d        = push ? ((wr_q == LAST) ? '0 : wr_q + PW'(1)) : wr_q;
    rd_d        = pop ? ((rd_q == LAST) ? '0 : rd_q + PW'(1)) : rd_q;
    cnt_d       = (push && !pop) ? cnt_q + CW'(1) : (pop && !push) ? cnt_q - CW'(1) : cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= in_data_i;
  end
endmodule

// File: rtl/tl_ul_buffer.sv
// tl_ul_buffer: independent A and D channel queues for TL-UL.
// Define TL_UL_BUFFER_FLOW_EN for zero-latency flow-through when a queue is empty.
module tl_ul_buffer
  import tl_ul_pkg::*;
#(
  parameter int A_DEPTH = 2,
  parameter int D_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        a_in_valid,
  output logic        a_in_ready,
  input  logic [2:0]  a_in_opcode,
  input  logic [2:0]  a_in_param,
  input  logic [3:0]  a_in_size,
  input  logic [3:0]  a_in_source,
  input  logic [31:0] a_in_address,
  input  logic [3:0]  a_in_mask,
  input  logic [31:0] a_in_data,
  input  logic        a_in_corrupt,
  output logic        a_out_valid,
  input  logic        a_out_ready,
  output logic [2:0]  a_out_opcode,
  output logic [2:0]  a_out_param,
  output logic [3:0]  a_out_size,
  output logic [3:0]  a_out_source,
  output logic [31:0] a_out_address,
  output logic [3:0]  a_out_mask,
  output logic [31:0] a_out_data,
  output logic        a_out_corrupt,
  input  logic        d_in_valid,
  output logic        d_in_ready,
  input  logic [2:0]  d_in_opcode,
  input  logic [1:0]  d_in_param,
  input  logic [3:0]  d_in_size,
  input  logic [3:0]  d_in_source,
  input  logic        d_in_sink,
  input  logic        d_in_denied,
  input  logic [31:0] d_in_data,
  input  logic        d_in_corrupt,
  output logic        d_out_valid,
  input  logic        d_out_ready,
  output logic [2:0]  d_out_opcode,
  output logic [1:0]  d_out_param,
  output logic [3:0]  d_out_size,
  output logic [3:0]  d_out_source,
  output logic        d_out_sink,
  output logic        d_out_denied,
  output logic [31:0] d_out_data,
  output logic        d_out_corrupt
);
`ifdef TL_UL_BUFFER_FLOW_EN
  localparam bit FLOW = 1'b1;
`else
  localparam bit FLOW = 1'b0;
`endif
  tl_a_beat_t a_in_b, a_out_b;
  tl_d_beat_t d_in_b, d_out_b;
  assign a_in_b = {a_in_opcode, a_in_param, a_in_size, a_in_source, a_in_address, a_in_mask, a_in_data, a_in_corrupt};
  assign {a_out_opcode, a_out_param, a_out_size, a_out_source, a_out_address, a_out_mask, a_out_data, a_out_corrupt} = a_out_b;
  assign d_in_b = {d_in_opcode, d_in_param, d_in_size, d_in_source, d_in_sink, d_in_denied, d_in_data, d_in_corrupt};
  assign {d_out_opcode, d_out_param, d_out_size, d_out_source, d_out_sink, d_out_denied, d_out_data, d_out_corrupt} = d_out_b;
  tl_ul_fifo #(.WIDTH($bits(tl_a_beat_t)), .DEPTH(A_DEPTH), .FLOW(FLOW)) u_a_fifo (
    .clk_i(clock), .rst_ni(reset_n),
    .in_valid_i(a_in_valid), .in_ready_o(a_in_ready), .in_data_i(a_in_b),
    .out_valid_o(a_out_valid), .out_ready_i(a_out_ready), .out_data_o(a_out_b)
  );
  tl_ul_fifo #(.WIDTH($bits(tl_d_beat_t)), .DEPTH(D_DEPTH), .FLOW(FLOW)) u_d_fifo (
    .clk_i(clock), .rst_ni(reset_n),
    .in_valid_i(d_in_valid), .in_ready_o(d_in_ready), .in_data_i(d_in_b),
    .out_valid_o(d_out_valid), .out_ready_i(d_out_ready), .out_data_o(d_out_b)
  );
endmodule
